// File: rtl/i2s_dac_tx_if.sv
// -----------------------------------------------------------------------------
// i2s_dac_tx_if
// Stereo sample stream bundle feeding the I2S DAC transmitter.
//   left_data / left_valid / left_ready    : left channel ready/valid stream
//   right_data / right_valid / right_ready : right channel ready/valid stream
// Modports:
//   master : sample producer (drives data/valid, observes ready)
//   slave  : sample consumer (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface i2s_dac_tx_if #(
   parameter int unsigned DATA_W = 16
);
   logic [DATA_W-1:0] left_data;
   logic              left_valid;
   logic              left_ready;
   logic [DATA_W-1:0] right_data;
   logic              right_valid;
   logic              right_ready;

   modport master (
      output left_data, left_valid, right_data, right_valid,
      input  left_ready, right_ready
   );

   modport slave (
      input  left_data, left_valid, right_data, right_valid,
      output left_ready, right_ready
   );
endinterface

// File: rtl/i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// i2s_dac_tx
// Buffers left/right samples in per-channel FIFOs and shifts them out in I2S
// format on the WM8731 DAC data pin. The codec masters BCLK and DACLRCK; both
// are synchronized into the clk domain and only their edges are used here.
// Ports:
//   i_clk, i_rst_n   : system clock, synchronous active-low reset
//   io_snk           : left/right sample stream sinks (slave modport)
//   i_aud_bclk       : codec bit clock (asynchronous)
//   i_aud_daclrck    : codec DAC LR clock (asynchronous), 0 = left, 1 = right
//   o_aud_dacdat     : registered serial DAC data
//   o_underrun       : one-cycle pulse when a slot loads from an empty FIFO
//   o_underrun_cnt   : saturating underrun count
// -----------------------------------------------------------------------------
module i2s_dac_tx #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   i2s_dac_tx_if.slave io_snk,
   input  logic        i_aud_bclk,
   input  logic        i_aud_daclrck,
   output logic        o_aud_dacdat,
   output logic        o_underrun,
   output logic [15:0] o_underrun_cnt
);
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned BitW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {StUnarmed, StDelay, StShift, StPad} state_e;

   // ---------------------------------------------------------------- sync
   logic [1:0] r_bclk_sync;
   logic [1:0] r_lrck_sync;
   logic       r_bclk_prev;
   logic       r_lr_q;
   logic       w_fall_evt;
   logic       w_lr_chg;
   logic       w_lr_new;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_bclk_sync <= '0;
         r_lrck_sync <= '0;
         r_bclk_prev <= 1'b0;
         r_lr_q      <= 1'b0;
      end else begin
         r_bclk_sync <= {r_bclk_sync[0], i_aud_bclk};
         r_lrck_sync <= {r_lrck_sync[0], i_aud_daclrck};
         r_bclk_prev <= r_bclk_sync[1];
         if (w_fall_evt) r_lr_q <= r_lrck_sync[1];
      end
   end

   assign w_fall_evt = r_bclk_prev & ~r_bclk_sync[1];
   assign w_lr_new   = r_lrck_sync[1];
   assign w_lr_chg   = w_fall_evt & (w_lr_new != r_lr_q);

   // ---------------------------------------------------------------- FIFOs
   // Index 0 = left, 1 = right.
   logic [DATA_W-1:0] r_mem     [2][FIFO_DEPTH];
   logic [PtrW-1:0]   r_wr_ptr  [2];
   logic [PtrW-1:0]   r_rd_ptr  [2];
   logic [CntW-1:0]   r_count   [2];
   logic [CntW-1:0]   w_count_nxt [2];
   logic [DATA_W-1:0] w_wdata   [2];
   logic [1:0]        r_ready;
   logic [1:0]        w_push;
   logic [1:0]        w_pop;
   logic [1:0]        w_empty;
   logic [DATA_W-1:0] w_head;
   logic              w_load;

   assign w_wdata[0] = io_snk.left_data;
   assign w_wdata[1] = io_snk.right_data;
   assign w_push[0]  = io_snk.left_valid & r_ready[0];
   assign w_push[1]  = io_snk.right_valid & r_ready[1];
   assign w_empty[0] = (r_count[0] == '0);
   assign w_empty[1] = (r_count[1] == '0);
   // An empty FIFO is never popped, even if a push lands in the same cycle.
   assign w_pop[0]   = w_load & ~w_lr_new & ~w_empty[0];
   assign w_pop[1]   = w_load & w_lr_new & ~w_empty[1];
   assign w_head     = r_mem[w_lr_new][r_rd_ptr[w_lr_new]];

   assign io_snk.left_ready  = r_ready[0];
   assign io_snk.right_ready = r_ready[1];

   always_comb begin
      for (int ch = 0; ch < 2; ch++) begin
         w_count_nxt[ch] = r_count[ch];
         if (w_push[ch] && !w_pop[ch]) begin
            w_count_nxt[ch] = r_count[ch] + CntW'(1);
         end else if (w_pop[ch] && !w_push[ch]) begin
            w_count_nxt[ch] = r_count[ch] - CntW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         if (w_push[ch]) r_mem[ch][r_wr_ptr[ch]] <= w_wdata[ch];
      end
   end

   always_ff @(posedge i_clk) begin
      for (int ch = 0; ch < 2; ch++) begin
         if (!i_rst_n) begin
            r_wr_ptr[ch] <= '0;
            r_rd_ptr[ch] <= '0;
            r_count[ch]  <= '0;
            r_ready[ch]  <= 1'b0;
         end else begin
            if (w_push[ch]) r_wr_ptr[ch] <= r_wr_ptr[ch] + PtrW'(1);
            if (w_pop[ch])  r_rd_ptr[ch] <= r_rd_ptr[ch] + PtrW'(1);
            r_count[ch] <= w_count_nxt[ch];
            // Ready reflects occupancy after this cycle's push/pop.
            r_ready[ch] <= (w_count_nxt[ch] != CntW'(FIFO_DEPTH));
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   state_e            r_state;
   state_e            w_state_nxt;
   logic [DATA_W-1:0] r_shreg;
   logic [BitW-1:0]   r_bit_cnt;
   logic              r_dacdat;
   logic              r_underrun;
   logic [15:0]       r_underrun_cnt;
   logic              w_shift;
   logic              w_clear;
   logic              w_bit_done;

   assign w_bit_done = (r_bit_cnt == '0);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= StUnarmed;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StUnarmed: if (w_lr_chg && !w_lr_new) w_state_nxt = StDelay;
         StDelay: begin
            if (w_lr_chg)        w_state_nxt = StDelay;
            else if (w_fall_evt) w_state_nxt = StShift;
         end
         StShift: begin
            if (w_lr_chg)                      w_state_nxt = StDelay;
            else if (w_fall_evt && w_bit_done) w_state_nxt = StPad;
         end
         StPad: if (w_lr_chg) w_state_nxt = StDelay;
      endcase
   end

   always_comb begin
      w_load  = 1'b0;
      w_shift = 1'b0;
      w_clear = 1'b0;
      unique case (r_state)
         // Arm only at the start of a left slot so frames stay aligned.
         StUnarmed: w_load = w_lr_chg & ~w_lr_new;
         StDelay: begin
            w_load  = w_lr_chg;
            w_shift = w_fall_evt & ~w_lr_chg;
         end
         StShift: begin
            w_load  = w_lr_chg;
            w_shift = w_fall_evt & ~w_lr_chg & ~w_bit_done;
            w_clear = w_fall_evt & ~w_lr_chg & w_bit_done;
         end
         StPad: w_load = w_lr_chg;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_shreg        <= '0;
         r_bit_cnt      <= '0;
         r_dacdat       <= 1'b0;
         r_underrun     <= 1'b0;
         r_underrun_cnt <= '0;
      end else begin
         r_underrun <= 1'b0;
         if (w_load) begin
            r_bit_cnt <= BitW'(DATA_W);
            r_dacdat  <= 1'b0;  // I2S one-bit delay slot
            if (w_empty[w_lr_new]) begin
               r_shreg    <= '0;
               r_underrun <= 1'b1;
               if (r_underrun_cnt != 16'hFFFF) r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end else begin
               r_shreg <= w_head;
            end
         end else if (w_shift) begin
            r_dacdat  <= r_shreg[DATA_W-1];
            r_shreg   <= r_shreg << 1;
            r_bit_cnt <= r_bit_cnt - BitW'(1);
         end else if (w_clear) begin
            r_dacdat <= 1'b0;
         end
      end
   end

   assign o_aud_dacdat   = r_dacdat;
   assign o_underrun     = r_underrun;
   assign o_underrun_cnt = r_underrun_cnt;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_dac_tx
// Directed bench for i2s_dac_tx: drives BCLK/LRCK as the codec would, captures
// aud_dacdat at each BCLK rising edge and compares against hand-built words.
// -----------------------------------------------------------------------------
module tb_i2s_dac_tx;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        aud_bclk;
   logic        aud_daclrck;
   logic        aud_dacdat;
   logic        underrun;
   logic [15:0] underrun_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int ur_pulses = 0;

   i2s_dac_tx_if #(.DATA_W(16)) snk ();

   i2s_dac_tx #(
      .DATA_W     (16),
      .FIFO_DEPTH (4)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .io_snk         (snk),
      .i_aud_bclk     (aud_bclk),
      .i_aud_daclrck  (aud_daclrck),
      .o_aud_dacdat   (aud_dacdat),
      .o_underrun     (underrun),
      .o_underrun_cnt (underrun_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (underrun === 1'b1) ur_pulses++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic do_reset(input logic lr);
      rst_n            = 1'b0;
      aud_daclrck      = lr;
      aud_bclk         = 1'b1;
      snk.left_valid   = 1'b0;
      snk.right_valid  = 1'b0;
      snk.left_data    = '0;
      snk.right_data   = '0;
      repeat (3) @(negedge clk);
      check("rst_dacdat", {31'd0, aud_dacdat}, 32'd0);
      check("rst_underrun", {31'd0, underrun}, 32'd0);
      check("rst_underrun_cnt", {16'd0, underrun_cnt}, 32'd0);
      check("rst_left_ready", {31'd0, snk.left_ready}, 32'd0);
      check("rst_right_ready", {31'd0, snk.right_ready}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_left_ready", {31'd0, snk.left_ready}, 32'd1);
      check("rel_right_ready", {31'd0, snk.right_ready}, 32'd1);
      repeat (4) @(negedge clk);
   endtask

   task automatic push(input logic ch, input logic [15:0] d);
      if (ch == 1'b0) begin
         snk.left_data  = d;
         snk.left_valid = 1'b1;
      end else begin
         snk.right_data  = d;
         snk.right_valid = 1'b1;
      end
      @(negedge clk);
      snk.left_valid  = 1'b0;
      snk.right_valid = 1'b0;
   endtask

   // One BCLK period (4 clk low, 4 clk high); LRCK changes with the fall.
   // Returns the bit present when the codec samples at the rising edge.
   task automatic bclk_fall(input logic lr, output logic b);
      aud_daclrck = lr;
      aud_bclk    = 1'b0;
      repeat (4) @(negedge clk);
      b        = aud_dacdat;
      aud_bclk = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic run_slot(input logic lr, input int n, output logic [31:0] bits);
      logic b;
      bits = '0;
      for (int i = 0; i < n; i++) begin
         bclk_fall(lr, b);
         bits = {bits[30:0], b};
      end
   endtask

   initial begin
      logic [31:0] bits;
      logic [15:0] w;
      logic        b;
      int          base;
      int          n_acc;
      logic        acc;

      // Basic frame
      do_reset(1'b0);
      push(1'b0, 16'hA5C3);
      push(1'b1, 16'h3C5A);
      base = ur_pulses;
      run_slot(1'b1, 32, bits);
      check("basic_unarmed_zero", bits, 32'd0);
      run_slot(1'b0, 32, bits);
      check("basic_left_word", bits, {1'b0, 16'hA5C3, 15'd0});
      run_slot(1'b1, 32, bits);
      check("basic_right_word", bits, {1'b0, 16'h3C5A, 15'd0});
      check("basic_no_underrun", ur_pulses - base, 32'd0);

      // Arm alignment: reset released mid right slot
      do_reset(1'b1);
      push(1'b0, 16'h1234);
      push(1'b1, 16'h5678);
      run_slot(1'b1, 12, bits);
      check("arm_mid_right_zero", bits, 32'd0);
      run_slot(1'b0, 32, bits);
      check("arm_left_head", bits, {1'b0, 16'h1234, 15'd0});
      run_slot(1'b1, 32, bits);
      check("arm_right_word", bits, {1'b0, 16'h5678, 15'd0});

      // Underrun on the right channel
      do_reset(1'b0);
      push(1'b0, 16'h7FFF);
      base = ur_pulses;
      run_slot(1'b1, 32, bits);
      run_slot(1'b0, 32, bits);
      check("ur_left_word", bits, {1'b0, 16'h7FFF, 15'd0});
      run_slot(1'b1, 32, bits);
      check("ur_right_zero", bits, 32'd0);
      check("ur_pulse_once", ur_pulses - base, 32'd1);
      check("ur_cnt_one", {16'd0, underrun_cnt}, 32'd1);
      run_slot(1'b0, 32, bits);
      check("ur_left_fifo_empty", bits, 32'd0);
      check("ur_cnt_two", {16'd0, underrun_cnt}, 32'd2);

      // Backpressure with BCLK idle
      do_reset(1'b0);
      snk.left_valid = 1'b1;
      n_acc = 0;
      for (int k = 0; k < 10; k++) begin
         snk.left_data = 16'h0100 + 16'(k);
         acc = snk.left_ready;
         @(negedge clk);
         if (acc) n_acc++;
      end
      snk.left_valid = 1'b0;
      check("bp_accepted", n_acc, 32'd4);
      check("bp_ready_low_full", {31'd0, snk.left_ready}, 32'd0);
      run_slot(1'b1, 2, bits);
      aud_daclrck = 1'b0;
      aud_bclk    = 1'b0;
      repeat (2) @(negedge clk);
      check("bp_ready_before_pop", {31'd0, snk.left_ready}, 32'd0);
      @(negedge clk);
      check("bp_ready_after_pop", {31'd0, snk.left_ready}, 32'd1);
      @(negedge clk);
      check("bp_delay_bit", {31'd0, aud_dacdat}, 32'd0);
      aud_bclk = 1'b1;
      repeat (4) @(negedge clk);
      run_slot(1'b0, 31, bits);
      check("bp_first_word", bits, {1'b0, 16'h0100, 15'd0});

      // Short slots: 10 BCLKs per channel
      do_reset(1'b0);
      push(1'b0, 16'hA5C3);
      push(1'b0, 16'h1111);
      push(1'b1, 16'h3C5A);
      push(1'b1, 16'h2222);
      base = ur_pulses;
      run_slot(1'b1, 10, bits);
      run_slot(1'b0, 10, bits);
      w = 16'hA5C3;
      check("short_l0", bits, {22'd0, 1'b0, w[15:7]});
      run_slot(1'b1, 10, bits);
      w = 16'h3C5A;
      check("short_r0", bits, {22'd0, 1'b0, w[15:7]});
      run_slot(1'b0, 10, bits);
      w = 16'h1111;
      check("short_l1", bits, {22'd0, 1'b0, w[15:7]});
      run_slot(1'b1, 10, bits);
      w = 16'h2222;
      check("short_r1", bits, {22'd0, 1'b0, w[15:7]});
      check("short_no_underrun", ur_pulses - base, 32'd0);

      // Saturation: preload near the top, then one-BCLK empty slots
      do_reset(1'b0);
      force dut.r_underrun_cnt = 16'hFFFD;
      @(negedge clk);
      release dut.r_underrun_cnt;
      @(negedge clk);
      base = ur_pulses;
      bclk_fall(1'b1, b);
      bclk_fall(1'b0, b);
      check("sat_fffe", {16'd0, underrun_cnt}, 32'h0000FFFE);
      bclk_fall(1'b1, b);
      check("sat_ffff", {16'd0, underrun_cnt}, 32'h0000FFFF);
      bclk_fall(1'b0, b);
      bclk_fall(1'b1, b);
      check("sat_hold", {16'd0, underrun_cnt}, 32'h0000FFFF);
      check("sat_pulses", ur_pulses - base, 32'd4);

      // Reset mid-word
      do_reset(1'b0);
      push(1'b0, 16'hFFFF);
      run_slot(1'b1, 2, bits);
      run_slot(1'b0, 3, bits);
      check("midrst_partial", bits, 32'b011);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_dacdat", {31'd0, aud_dacdat}, 32'd0);
      do_reset(1'b0);
      run_slot(1'b1, 32, bits);
      check("midrst_rearm_zero", bits, 32'd0);
      run_slot(1'b0, 32, bits);
      check("midrst_no_partial", bits, 32'd0);
      check("midrst_underrun_cnt", {16'd0, underrun_cnt}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
